// File: rtl/arbiter_n_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arbiter_n_sync                                                |
// | Purpose  : Registered N-requester arbiter, fixed or round-robin policy,  |
// |            grant locked until release, chain en/any for cascading.       |
// |            Optional macro ARB_HOLD_LIMIT_EN caps a holder at HOLD_MAX.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module arbiter_n_sync #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] r,
    output logic [N-1:0] g,
    output logic         any,
    output logic         busy
);

    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_g;
    logic [N-1:0]    w_g_nxt;
    logic            r_busy;
    logic [IW-1:0]   r_h;
    logic [IW-1:0]   w_h_nxt;
    logic [IW-1:0]   r_p;
    logic [IW-1:0]   w_p_nxt;
    logic [N-1:0]    w_hmask;
    logic [N-1:0]    w_req;
    logic            w_force;
    logic            w_decide;
    logic [IW-1:0]   w_fix_win;
    logic [IW-1:0]   w_rr_win;
    logic            w_rr_found;
    logic [IW-1:0]   w_win;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    // Pre-empt only when someone else is waiting; otherwise the holder keeps g.
    assign w_force = (r_state == ST_GRANT) && r[r_h] &&
                     (r_cnt == CW'(HOLD_MAX)) && (|(r & ~w_hmask));
`else
    assign w_force = 1'b0;
`endif

    assign any      = |r;
    assign g        = r_g;
    assign busy     = r_busy;
    assign w_hmask  = {{(N-1){1'b0}}, 1'b1} << r_h;
    assign w_req    = w_force ? (r & ~w_hmask) : r;
    assign w_decide = (r_state == ST_IDLE) || !r[r_h] || w_force;
    assign w_win    = mode ? w_rr_win : w_fix_win;

    always_comb begin
        w_fix_win = '0;
        for (int i = 0; i < N; i++) begin
            if (w_req[i]) w_fix_win = IW'(i);
        end
    end

    // Ascending search starting one past the last winner, wrapping at N.
    always_comb begin
        int idx;
        w_rr_win   = '0;
        w_rr_found = 1'b0;
        idx        = 0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(r_p) + off;
            if (idx >= N) idx = idx - N;
            if (!w_rr_found && w_req[idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = IW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_h_nxt     = r_h;
        w_p_nxt     = r_p;
`ifdef ARB_HOLD_LIMIT_EN
        w_cnt_nxt   = r_cnt;
`endif
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_g_nxt     = '0;
`ifdef ARB_HOLD_LIMIT_EN
            w_cnt_nxt   = '0;
`endif
        end else if (w_decide) begin
            if (|w_req) begin
                w_state_nxt = ST_GRANT;
                w_g_nxt     = {{(N-1){1'b0}}, 1'b1} << w_win;
                w_h_nxt     = w_win;
                w_p_nxt     = w_win;
`ifdef ARB_HOLD_LIMIT_EN
                w_cnt_nxt   = CW'(1);
`endif
            end else begin
                w_state_nxt = ST_IDLE;
                w_g_nxt     = '0;
`ifdef ARB_HOLD_LIMIT_EN
                w_cnt_nxt   = '0;
`endif
            end
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            if (r_cnt != CW'(HOLD_MAX)) w_cnt_nxt = r_cnt + CW'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_g     <= '0;
            r_busy  <= 1'b0;
            r_h     <= '0;
            r_p     <= IW'(N - 1);
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_busy  <= |w_g_nxt;
            r_h     <= w_h_nxt;
            r_p     <= w_p_nxt;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= w_cnt_nxt;
    end
`endif

endmodule
`default_nettype wire

// File: doc/arbiter_n_sync.md
# arbiter_n_sync

Registered, parametrised N-requester arbiter; next generation of the team's combinational 4-input fixed-priority arbiter. Adds a clock, grant locking until release, a runtime-selectable fixed or round-robin policy, and chain enable/any signals so instances cascade into a wider daisy chain. Sits between bus requesters and a shared resource; one instance per arbitration domain.

## Interface
- N, 4, number of requesters (2..32)
- HOLD_MAX, 8, max consecutive grant cycles per holder (used only with ARB_HOLD_LIMIT_EN; 1..255)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- en  input  1  chain enable; 0 forces all grants low
- mode  input  1  0 = fixed priority, 1 = round-robin
- r  input  N  request vector, bit i = requester i
- g  output  N  grant vector, registered, one-hot or zero
- any  output  1  combinational OR of r (upstream chain request)
- busy  output  1  registered, 1 while g != 0

## Operation
- States: IDLE (g = 0), GRANT (g one-hot, holder index h stored).
- Arbitration decision taken in any cycle where state is IDLE, or state is GRANT and r[h] = 0 (release); result loaded into g at the next rising edge.
- Fixed mode: highest requesting index wins (r = 0b0110 -> g = 0b0100).
- Round-robin mode: pointer p = last granted index; search starts at (p+1) mod N, ascending with wrap; first requester found wins; p <- winner on every grant.
- Lock: while in GRANT and r[h] = 1, g holds, no other requester considered (subject to Configuration).
- Release with other requests pending: g moves directly to the new winner at that edge (no idle cycle). Release with none pending: g -> 0, state IDLE.
- en = 0: at next edge g -> 0, IDLE; p unchanged. Requests ignored while en = 0.
- mode change during GRANT: current grant unaffected; new policy applies at next decision.
- Requests appearing and the holder releasing in the same cycle: both visible to the same decision.
- Reset values: g = 0, busy = 0, state IDLE, p = N-1 (first round-robin search starts at 0), hold counter = 0. any is combinational and follows r during reset.
- Reset asserted mid-grant: g, busy drop immediately (asynchronous), no edge required.

## Timing
- Request-to-grant latency: 1 clock (r sampled at edge k, g valid after edge k).
- Release-to-regrant latency: 1 clock.
- en deassert to g = 0: 1 clock.
- busy is coincident with g (same edge).
- any has zero latency, combinational from r only.
- No combinational path from r to g.

## Configuration
- ARB_HOLD_LIMIT_EN defined: counter c (width clog2(HOLD_MAX+1)) increments each GRANT cycle, reset to 1 on each new grant. When c = HOLD_MAX and any r[j] = 1 for j != h, a forced decision occurs with r[h] masked for that decision; g moves to the winner at the next edge. If no other request, holder keeps g and c saturates at HOLD_MAX until another request appears.
- ARB_HOLD_LIMIT_EN not defined: no counter; holder keeps grant indefinitely while r[h] = 1; HOLD_MAX ignored.

## Test plan
- Reset: rst_n low with r = all ones -> g = 0, busy = 0 immediately; after release, g = 0b1000 (N=4, mode 0) one edge later.
- Fixed priority/lock: mode 0, r = 0b0011 -> g = 0b0010; then r = 0b1011 -> g stays 0b0010; drop r[1] -> g = 0b1000 next edge, no zero cycle.
- Round-robin wrap: mode 1, r = 0b1111 held, each holder releases after 1 cycle and re-requests -> grant sequence 0b0001, 0b0010, 0b0100, 0b1000, 0b0001.
- Enable: mid-grant en = 0 -> g = 0 next edge; en = 1 with r = 0b0100 -> g = 0b0100 next edge; any tracks r throughout.
- Hold limit (macro on, HOLD_MAX = 3, mode 0): r = 0b1001 held -> g = 0b1000 for exactly 3 cycles, then 0b0001; with only r[3] requesting -> g = 0b1000 indefinitely.
- Async reset mid-grant: assert rst_n low between edges while g = 0b0100 -> g = 0 before next edge; p returns to N-1.
